// File: rtl/fma_pipe_param.sv
// Seven-stage fused multiply-add with a valid bit per stage, global stall and
// truncating (round-toward-zero) rounding; special operands bypass the arithmetic.
module fma_pipe_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a_multiplicand,
  input  logic [EXP_W+MAN_W:0]   b_multiplier,
  input  logic [EXP_W+MAN_W:0]   c_addition,
  input  logic [1:0]             mode,
  input  logic [TAG_W-1:0]       tag_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   accumulate,
  output logic [TAG_W-1:0]       tag_out,
  output logic [2:0]             flags,
  output logic                   busy
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;        // hidden bit, fraction, guard, round, sticky
  localparam int PW  = 2 * MAN_W + 2;
  localparam int EW2 = EXP_W + 2;        // signed working exponent
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EW2-1:0]   EXP_TOP  = {2'b00, EXP_ONES};
  localparam logic [EW2-1:0]   BIAS_X   = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [EW2-1:0]   SW_X     = EW2'(SW);
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0]     ONE      = {2'b00, {(EXP_W-1){1'b1}}, {MAN_W{1'b0}}};

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             spec;
    logic [W-1:0]     sres;
    logic [2:0]       sflg;
  } side_t;

  // Handshake: an input transfers on in_valid && in_ready, a result on
  // out_valid && out_ready; a held result (out_valid && !out_ready) freezes every stage.
  logic stall;
  logic [7:1] vld;
  side_t sd [1:6];

  assign stall     = vld[7] && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = vld[7];
  assign busy      = |vld;

  // Returns {nan, inf, zero}; exp == 0 counts as zero so denormals are flushed.
  function automatic logic [2:0] classify(input logic [W-2:0] x);
    logic mx;
    mx = &x[W-2:MAN_W];
    return {mx && |x[MAN_W-1:0], mx && ~|x[MAN_W-1:0], ~|x[W-2:MAN_W]};
  endfunction

  // ---------------- stage 1: operand selection and special-case decode
  logic [W-1:0] b_eff, c_eff, sres_n;
  logic [2:0]   ca, cb, cc, sflg_n;
  logic         p_sign, p_inf, p_zero, spec_n;

  always_comb begin
    b_eff = b_multiplier;
    c_eff = c_addition;
    case (mode)
      2'b01:   c_eff[W-1] = ~c_addition[W-1];
      2'b10:   c_eff = '0;
      2'b11:   b_eff = ONE;
      default: ;
    endcase
  end

  assign ca     = classify(a_multiplicand[W-2:0]);
  assign cb     = classify(b_eff[W-2:0]);
  assign cc     = classify(c_eff[W-2:0]);
  assign p_sign = a_multiplicand[W-1] ^ b_eff[W-1];
  assign p_inf  = ca[1] | cb[1];
  assign p_zero = ca[0] | cb[0];

  always_comb begin
    spec_n = 1'b1;
    sres_n = QNAN;
    sflg_n = 3'b000;
    if (ca[2] | cb[2] | cc[2]) sflg_n = 3'b000;
    else if (p_inf && p_zero) sflg_n = 3'b100;
    else if (p_inf && cc[1] && (p_sign != c_eff[W-1])) sflg_n = 3'b100;
    else if (p_inf) sres_n = {p_sign, EXP_ONES, {MAN_W{1'b0}}};
    else if (cc[1]) sres_n = {c_eff[W-1], EXP_ONES, {MAN_W{1'b0}}};
    else spec_n = 1'b0;
  end

  logic             s1_ps, s1_pz, s1_cs, s1_cz;
  logic [EXP_W-1:0] s1_ea, s1_eb, s1_ce;
  logic [MAN_W:0]   s1_ma, s1_mb, s1_cm;
  logic             s2_ps, s2_pz, s2_cs, s2_cz;
  logic [EW2-1:0]   s2_pe;
  logic [PW-1:0]    s2_prod;
  logic [EXP_W-1:0] s2_ce;
  logic [MAN_W:0]   s2_cm;
  logic             s3_ps, s3_pz, s3_cs, s3_cz;
  logic [EW2-1:0]   s3_pe;
  logic [SW-1:0]    s3_pm, s3_cm;
  logic [EXP_W-1:0] s3_ce;
  logic             s4_bs, s4_ss;
  logic [SW-1:0]    s4_bm, s4_sm;
  logic [EW2-1:0]   s4_be;
  logic [SW:0]      s5_sum;
  logic             s5_s;
  logic [EW2-1:0]   s5_e;
  logic [MAN_W-1:0] s6_f;
  logic [EW2-1:0]   s6_e;
  logic             s6_s, s6_z;

  // ---------------- stage 4: swap so the larger-exponent addend is "big", align the other
  logic            p_big, sm_s, big_s_n;
  logic [SW-1:0]   big_m_n, sm_m, sh_n;
  logic [EW2-1:0]  big_e_n, sm_e, d_n;
  logic [2*SW-1:0] ext;

  always_comb begin
    p_big = s3_cz || (!s3_pz && ($signed(s3_pe) >= $signed({2'b00, s3_ce})));
    if (p_big) begin
      big_m_n = s3_pm;  big_e_n = s3_pe;            big_s_n = s3_ps;
      sm_m    = s3_cm;  sm_e    = {2'b00, s3_ce};   sm_s    = s3_cs;
    end else begin
      big_m_n = s3_cm;  big_e_n = {2'b00, s3_ce};   big_s_n = s3_cs;
      sm_m    = s3_pm;  sm_e    = s3_pe;            sm_s    = s3_ps;
    end
    d_n = big_e_n - sm_e;
    ext = {sm_m, {SW{1'b0}}} >> d_n;
    if ($signed(d_n) < 0 || $signed(d_n) >= $signed(SW_X))
      sh_n = {{(SW-1){1'b0}}, |sm_m};
    else
      sh_n = {ext[2*SW-1:SW+1], ext[SW] | (|ext[SW-1:0])};
  end

  // ---------------- stage 5: signed-magnitude add
  logic [SW:0] sum_n;
  logic        sgn_n;

  always_comb begin
    sgn_n = s4_bs;
    if (s4_bs == s4_ss) sum_n = {1'b0, s4_bm} + {1'b0, s4_sm};
    else if (s4_bm >= s4_sm) sum_n = {1'b0, s4_bm - s4_sm};
    else begin
      sum_n = {1'b0, s4_sm - s4_bm};
      sgn_n = s4_ss;
    end
    // Exact zero is +0 unless both addends were negative.
    if (sum_n == '0) sgn_n = s4_bs & s4_ss;
  end

  // ---------------- stage 6: normalise (carry right-shift or leading-zero left-shift)
  logic [EW2-1:0] lz, ne;
  logic [SW-1:0]  nm;

  always_comb begin
    lz = '0;
    for (int i = 0; i < SW; i++) if (s5_sum[i]) lz = EW2'(SW - 1 - i);
    if (s5_sum[SW]) begin
      nm = {s5_sum[SW:2], s5_sum[1] | s5_sum[0]};
      ne = s5_e + 1'b1;
    end else begin
      nm = s5_sum[SW-1:0] << lz;
      ne = s5_e - lz;
    end
  end

  // ---------------- stage 7: pack with overflow/underflow handling
  logic [W-1:0] res_n;
  logic [2:0]   flg_n;

  always_comb begin
    res_n = {s6_s, s6_e[EXP_W-1:0], s6_f};
    flg_n = 3'b000;
    if (sd[6].spec) begin
      res_n = sd[6].sres;
      flg_n = sd[6].sflg;
    end else if (s6_z) res_n = {s6_s, {(W-1){1'b0}}};
    else if ($signed(s6_e) >= $signed(EXP_TOP)) begin
      res_n = {s6_s, EXP_ONES, {MAN_W{1'b0}}};
      flg_n = 3'b010;
    end else if (s6_e[EW2-1] || s6_e == '0) begin
      res_n = {s6_s, {(W-1){1'b0}}};
      flg_n = 3'b001;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) vld <= '0;
    else if (!stall) vld <= {vld[6:1], in_valid};
  end

  always_ff @(posedge clock) begin
    if (!stall) begin
      sd[1] <= '{tag: tag_in, spec: spec_n, sres: sres_n, sflg: sflg_n};
      for (int i = 2; i <= 6; i++) sd[i] <= sd[i-1];
      s1_ps <= p_sign;  s1_pz <= p_zero;
      s1_ea <= a_multiplicand[W-2:MAN_W];
      s1_eb <= b_eff[W-2:MAN_W];
      s1_ma <= ca[0] ? '0 : {1'b1, a_multiplicand[MAN_W-1:0]};
      s1_mb <= cb[0] ? '0 : {1'b1, b_eff[MAN_W-1:0]};
      s1_cs <= c_eff[W-1];  s1_cz <= cc[0];
      s1_ce <= c_eff[W-2:MAN_W];
      s1_cm <= cc[0] ? '0 : {1'b1, c_eff[MAN_W-1:0]};
      s2_prod <= PW'(s1_ma) * PW'(s1_mb);
      s2_pe   <= {2'b00, s1_ea} + {2'b00, s1_eb} - BIAS_X;
      s2_ps <= s1_ps;  s2_pz <= s1_pz;  s2_cs <= s1_cs;  s2_cz <= s1_cz;
      s2_ce <= s1_ce;  s2_cm <= s1_cm;
      // Keep hidden bit, fraction, guard and round; everything below folds into sticky.
      if (s2_prod[PW-1]) begin
        s3_pm <= {s2_prod[PW-1 -: MAN_W+3], |s2_prod[PW-MAN_W-4:0]};
        s3_pe <= s2_pe + 1'b1;
      end else begin
        s3_pm <= {s2_prod[PW-2 -: MAN_W+3], |s2_prod[PW-MAN_W-5:0]};
        s3_pe <= s2_pe;
      end
      s3_ps <= s2_ps;  s3_pz <= s2_pz;  s3_cs <= s2_cs;  s3_cz <= s2_cz;
      s3_ce <= s2_ce;  s3_cm <= {s2_cm, 3'b000};
      s4_bm <= big_m_n;  s4_be <= big_e_n;  s4_bs <= big_s_n;
      s4_sm <= sh_n;     s4_ss <= sm_s;
      s5_sum <= sum_n;  s5_s <= sgn_n;  s5_e <= s4_be;
      s6_f <= nm[SW-2:3];  s6_e <= ne;  s6_s <= s5_s;  s6_z <= ~|nm;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      accumulate <= '0;
      tag_out    <= '0;
      flags      <= '0;
    end else if (!stall && vld[6]) begin
      accumulate <= res_n;
      tag_out    <= sd[6].tag;
      flags      <= flg_n;
    end
  end
endmodule

// File: tb/tb_fma_pipe_param.sv
// Directed bench for fma_pipe_param at default parameters: latency, arithmetic
// corner cases, stall/backpressure ordering and mid-stream reset.
module tb_fma_pipe_param;
  localparam int W     = 32;
  localparam int TAG_W = 8;
  localparam int EW    = W + TAG_W + 3;

  logic             clock, reset;
  logic             in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]     a_multiplicand, b_multiplier, c_addition, accumulate;
  logic [1:0]       mode;
  logic [TAG_W-1:0] tag_in, tag_out;
  logic [2:0]       flags;

  fma_pipe_param dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_multiplicand(a_multiplicand), .b_multiplier(b_multiplier),
    .c_addition(c_addition), .mode(mode), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .accumulate(accumulate),
    .tag_out(tag_out), .flags(flags), .busy(busy)
  );

  // ---------------- clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] held_res;
  logic held_ok = 1'b0;
  int stall_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset && out_valid && !out_ready) begin
      check("in_ready_stall", 64'(in_ready), 0);
      if (held_ok) check("hold_result", 64'(accumulate), 64'(held_res));
      held_res  = accumulate;
      held_ok   = 1'b1;
      stall_cnt++;
    end else begin
      held_ok = 1'b0;
      if (reset && out_valid) begin
        if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 0);
        else begin
          exp_e = exp_q.pop_front();
          check("result", 64'(accumulate), 64'(exp_e[EW-1 -: W]));
          check("tag", 64'(tag_out), 64'(exp_e[TAG_W+2:3]));
          check("flags", 64'(flags), 64'(exp_e[2:0]));
        end
      end
    end
  end

  // ---------------- driver tasks (start and end on a falling edge)
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [1:0] m, input logic [TAG_W-1:0] t,
                       input logic [W-1:0] res, input logic [2:0] f);
    int g = 0;
    in_valid = 1'b1;
    a_multiplicand = a;  b_multiplier = b;  c_addition = c;  mode = m;  tag_in = t;
    while (!in_ready && g < 50) begin
      @(negedge clock);
      g++;
    end
    if (g >= 50) check("in_ready_timeout", 64'(in_ready), 1);
    exp_q.push_back({res, t, f});
    @(negedge clock);
  endtask

  task automatic run_single(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                            input logic [1:0] m, input logic [TAG_W-1:0] t,
                            input logic [W-1:0] res, input logic [2:0] f);
    int lat;
    drive(a, b, c, m, t, res, f);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("latency", 64'(lat), 7);
    @(negedge clock);
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 100) begin
      @(negedge clock);
      g++;
    end
    if (g >= 100) check("drain_timeout", 64'(exp_q.size()), 0);
  endtask

  // ---------------- stream vectors: a, b, c, mode, expected result, expected flags
  logic [W-1:0] st_a [10] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F800000,
                              32'h3FC00000, 32'hC0000000, 32'h7F800001, 32'h7F800000, 32'h80000000};
  logic [W-1:0] st_b [10] = '{32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000, 32'h00000000,
                              32'h40000000, 32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
  logic [W-1:0] st_c [10] = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h3F800000,
                              32'h3F000000, 32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h80000000};
  logic [1:0]   st_m [10] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 2'b01, 2'b11};
  logic [W-1:0] st_r [10] = '{32'h40E00000, 32'h40A00000, 32'h00000000, 32'h40C00000, 32'h40000000,
                              32'h40600000, 32'hC0A00000, 32'h7FC00000, 32'h7FC00000, 32'h80000000};
  logic [2:0]   st_f [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                              3'b000, 3'b000, 3'b000, 3'b100, 3'b000};

  initial begin
    reset = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;
    a_multiplicand = '0;  b_multiplier = '0;  c_addition = '0;  mode = 2'b00;  tag_in = '0;
    repeat (3) @(negedge clock);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_accumulate", 64'(accumulate), 0);
    check("rst_tag_out", 64'(tag_out), 0);
    check("rst_flags", 64'(flags), 0);
    reset = 1'b1;

    // Directed single operations.
    run_single(32'h40000000, 32'h40400000, 32'h3F800000, 2'b00, 8'h5A, 32'h40E00000, 3'b000);
    run_single(32'h40000000, 32'h40400000, 32'h3F800000, 2'b01, 8'h5B, 32'h40A00000, 3'b000);
    run_single(32'h3F800000, 32'h40400000, 32'hBF800000, 2'b11, 8'h5C, 32'h00000000, 3'b000);
    run_single(32'h7F800000, 32'h00000000, 32'h3F800000, 2'b10, 8'h5D, 32'h7FC00000, 3'b100);
    run_single(32'h7F000000, 32'h40000000, 32'h40000000, 2'b10, 8'h5E, 32'h7F800000, 3'b010);
    run_single(32'h00800000, 32'h3F000000, 32'h00000000, 2'b10, 8'h60, 32'h00000000, 3'b001);
    run_single(32'h3FC00000, 32'h40400000, 32'hBF800000, 2'b11, 8'h61, 32'h3F000000, 3'b000);
    run_single(32'h7F7FFFFF, 32'h40400000, 32'h7F7FFFFF, 2'b11, 8'h62, 32'h7F800000, 3'b010);
    run_single(32'hFF800000, 32'h40000000, 32'h3F800000, 2'b00, 8'h63, 32'hFF800000, 3'b000);
    run_single(32'h3FC00000, 32'h3F800001, 32'h00000000, 2'b10, 8'h64, 32'h3FC00001, 3'b000);
    run_single(32'h00400000, 32'h7F000000, 32'h00000000, 2'b10, 8'h65, 32'h00000000, 3'b000);
    run_single(32'h3F800000, 32'h00000000, 32'hB0800000, 2'b11, 8'h66, 32'h3F7FFFFF, 3'b000);
    run_single(32'h3F800000, 32'h00000000, 32'h30800000, 2'b11, 8'h67, 32'h3F800000, 3'b000);
    wait_drain();

    // Back-to-back stream with the consumer stalling for cycles 8-12.
    stall_cnt = 0;
    fork
      begin
        repeat (7) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1 out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 10; i++)
          drive(st_a[i], st_b[i], st_c[i], st_m[i], 8'h10 + 8'(i), st_r[i], st_f[i]);
        in_valid = 1'b0;
      end
    join
    wait_drain();
    check("stall_cycles", 64'(stall_cnt), 5);

    // Reset with four operations in flight.
    for (int i = 0; i < 4; i++)
      drive(st_a[i], st_b[i], st_c[i], st_m[i], 8'h20 + 8'(i), st_r[i], st_f[i]);
    check("busy_in_flight", 64'(busy), 1);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 0);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_in_ready", 64'(in_ready), 1);
    check("midrst_accumulate", 64'(accumulate), 0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    repeat (12) @(negedge clock);
    check("post_rst_busy", 64'(busy), 0);
    run_single(32'h40000000, 32'h40400000, 32'h3F800000, 2'b00, 8'hA5, 32'h40E00000, 3'b000);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
